// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwr_pkg.sv
// Shared types and constants for the power-row sequencer.
package gf180mcu_fd_sc_mcu9t5v0__pwr_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_RAMP_UP,
    ST_RESTORE,
    ST_ON,
    ST_ISO,
    ST_SAVE,
    ST_RAMP_DN
  } pwr_state_e;

  // A programmed dwell of zero behaves as this many cycles.
  localparam int unsigned DWELL_ZERO_SUB = 1;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwr_dwell_cnt.sv
// Dwell timer: loads D-1 on start, counts down, ticks at zero and reloads.
module gf180mcu_fd_sc_mcu9t5v0__pwr_dwell_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] reload_q, reload_d;

  always_comb begin
    reload_d = reload_q;
    cnt_d    = cnt_q;
    if (start) begin
      reload_d = load_val;
      cnt_d    = load_val;
    end else if (cnt_q == '0) begin
      cnt_d = reload_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      reload_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwr_row_seq.sv
// Power-row sequencer: row-by-row header switching with isolation and retention ordering.
//   state      | meaning
//   OFF        | all rows off, clamped, waiting for request
//   RAMP_UP    | enabling one more row every D cycles, then one extra dwell
//   RESTORE    | one-cycle retention restore, still clamped
//   ON         | fully powered, unclamped, acknowledged
//   ISO        | clamp asserted ahead of save
//   SAVE       | one-cycle retention save
//   RAMP_DN    | dropping one row every D cycles, top row first
module gf180mcu_fd_sc_mcu9t5v0__pwr_row_seq
  import gf180mcu_fd_sc_mcu9t5v0__pwr_pkg::*;
#(
  parameter int NROWS   = 8,
  parameter int DWELL_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               PWR_REQ,
  input  logic [DWELL_W-1:0] DWELL,
  output logic               PWR_ACK,
  output logic               BUSY,
  output logic [NROWS-1:0]   SW_EN,
  output logic               ISO,
  output logic               SAVE,
  output logic               RESTORE
);

  localparam int RW = $clog2(NROWS);

  pwr_state_e         state_q, state_d;
  logic [RW-1:0]      row_q, row_d;
  logic [NROWS-1:0]   sw_en_q, sw_en_d;
  logic               req_q, req_d;
  logic               iso_q, iso_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               save_q, save_d;
  logic               restore_q, restore_d;
  logic               cnt_start;
  logic               tick;
  logic [DWELL_W-1:0] dwell_m1;

  assign dwell_m1 = (DWELL == '0) ? DWELL_W'(DWELL_ZERO_SUB - 1) : DWELL - 1'b1;

  gf180mcu_fd_sc_mcu9t5v0__pwr_dwell_cnt #(.W(DWELL_W)) u_dwell_cnt (
    .clk      (CLK),
    .rst      (RST),
    .start    (cnt_start),
    .load_val (dwell_m1),
    .tick     (tick)
  );

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    sw_en_d   = sw_en_q;
    cnt_start = 1'b0;
    req_d     = PWR_REQ;
    case (state_q)
      ST_OFF: begin
        if (req_q) begin
          state_d   = ST_RAMP_UP;
          sw_en_d   = NROWS'(1);
          row_d     = '0;
          cnt_start = 1'b1;
        end
      end
      ST_RAMP_UP: begin
        if (tick) begin
          if (row_q == RW'(NROWS - 1)) begin
            state_d = ST_RESTORE;
          end else begin
            row_d   = row_q + 1'b1;
            sw_en_d = {sw_en_q[NROWS-2:0], 1'b1};
          end
        end
      end
      ST_RESTORE: state_d = ST_ON;
      ST_ON: begin
        if (!req_q) state_d = ST_ISO;
      end
      ST_ISO:  state_d = ST_SAVE;
      ST_SAVE: begin
        state_d   = ST_RAMP_DN;
        sw_en_d   = sw_en_q >> 1;
        row_d     = RW'(NROWS - 1);
        cnt_start = 1'b1;
      end
      ST_RAMP_DN: begin
        if (tick) begin
          if (row_q == '0) begin
            state_d = ST_OFF;
          end else begin
            row_d   = row_q - 1'b1;
            sw_en_d = sw_en_q >> 1;
          end
        end
      end
      default: state_d = ST_OFF;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    iso_d     = (state_d != ST_ON);
    ack_d     = (state_d == ST_ON);
    busy_d    = (state_d != ST_ON) && (state_d != ST_OFF);
    save_d    = (state_d == ST_SAVE);
    restore_d = (state_d == ST_RESTORE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_OFF;
      row_q     <= '0;
      sw_en_q   <= '0;
      req_q     <= 1'b0;
      iso_q     <= 1'b1;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      save_q    <= 1'b0;
      restore_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      sw_en_q   <= sw_en_d;
      req_q     <= req_d;
      iso_q     <= iso_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      save_q    <= save_d;
      restore_q <= restore_d;
    end
  end

  assign SW_EN   = sw_en_q;
  assign ISO     = iso_q;
  assign PWR_ACK = ack_q;
  assign BUSY    = busy_q;
  assign SAVE    = save_q;
  assign RESTORE = restore_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__pwr_row_seq.sv
// Directed bench for the power-row sequencer: table of ramp scenarios plus a reset corner case.
module tb_gf180mcu_fd_sc_mcu9t5v0__pwr_row_seq;

  logic       CLK = 1'b0;
  logic       RST;
  logic       PWR_REQ;
  logic [7:0] DWELL;
  logic       PWR_ACK, BUSY, ISO, SAVE, RESTORE;
  logic [7:0] SW_EN;

  int n_chk = 0;
  int n_err = 0;
  int edge_n = 0;

  typedef struct {
    logic [7:0] dwell;
    int         d_eff;
    int         glitch_at;
    int         glitch_len;
    int         drop_at;
    int         exp_ack;   // edges from request sample to ACK rise
    int         exp_off;   // edges from release sample to BUSY fall
  } vec_t;

  vec_t vecs[6];

  gf180mcu_fd_sc_mcu9t5v0__pwr_row_seq #(.NROWS(8), .DWELL_W(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .PWR_REQ (PWR_REQ),
    .DWELL   (DWELL),
    .PWR_ACK (PWR_ACK),
    .BUSY    (BUSY),
    .SW_EN   (SW_EN),
    .ISO     (ISO),
    .SAVE    (SAVE),
    .RESTORE (RESTORE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    edge_n++;
    if (ISO === 1'b0) check("iso_low_needs_all_rows", 32'(SW_EN), 32'hFF);
    check("save_restore_exclusive", 32'(SAVE & RESTORE), 32'd0);
  endtask

  task automatic power_up(input vec_t v, input int idx);
    int k, rst_e, ack_e;
    int rise[8];
    k = edge_n + 1;
    PWR_REQ = 1'b1;
    DWELL = v.dwell;
    for (int i = 0; i < 8; i++) rise[i] = -1;
    rst_e = -1;
    ack_e = -1;
    for (int n = 0; n < 400 && ack_e < 0; n++) begin
      tick();
      for (int i = 0; i < 8; i++) if (rise[i] < 0 && SW_EN[i] === 1'b1) rise[i] = edge_n;
      if (rst_e < 0 && RESTORE === 1'b1) rst_e = edge_n;
      if (PWR_ACK === 1'b1) ack_e = edge_n;
      if (n == v.glitch_at) begin
        PWR_REQ = 1'b0;
        DWELL = 8'd200;
      end
      if (n == v.glitch_at + v.glitch_len) PWR_REQ = 1'b1;
      if (n == v.drop_at) PWR_REQ = 1'b0;
    end
    for (int i = 0; i < 8; i++)
      check($sformatf("v%0d_row%0d_on_edge", idx, i), 32'(rise[i]), 32'(k + 1 + i * v.d_eff));
    check($sformatf("v%0d_restore_edge", idx), 32'(rst_e), 32'(k + 1 + 8 * v.d_eff));
    check($sformatf("v%0d_ack_delay", idx), 32'(ack_e - k), 32'(v.exp_ack));
    check($sformatf("v%0d_iso_at_on", idx), 32'(ISO), 32'd0);
    check($sformatf("v%0d_busy_at_on", idx), 32'(BUSY), 32'd0);
  endtask

  task automatic power_down(input vec_t v, input int idx, input int j_off);
    int j, ackf, save_e, busy_f;
    bit busy_seen, iso_low;
    int fall[8];
    j = edge_n + j_off;
    PWR_REQ = 1'b0;
    DWELL = v.dwell;
    for (int i = 0; i < 8; i++) fall[i] = -1;
    ackf = -1; save_e = -1; busy_f = -1;
    busy_seen = 0; iso_low = 0;
    for (int n = 0; n < 400 && busy_f < 0; n++) begin
      tick();
      if (ackf < 0 && PWR_ACK === 1'b0) ackf = edge_n;
      if (save_e < 0 && SAVE === 1'b1) save_e = edge_n;
      for (int i = 0; i < 8; i++) if (fall[i] < 0 && SW_EN[i] === 1'b0) fall[i] = edge_n;
      if (BUSY === 1'b1) busy_seen = 1;
      else if (busy_seen) busy_f = edge_n;
      if (busy_seen && ISO !== 1'b1) iso_low = 1;
    end
    check($sformatf("v%0d_ack_fall", idx), 32'(ackf - j), 32'd1);
    check($sformatf("v%0d_save_edge", idx), 32'(save_e - j), 32'd2);
    for (int i = 0; i < 8; i++)
      check($sformatf("v%0d_row%0d_off_edge", idx, 7 - i), 32'(fall[7 - i] - j), 32'(3 + i * v.d_eff));
    check($sformatf("v%0d_busy_fall", idx), 32'(busy_f - j), 32'(v.exp_off));
    check($sformatf("v%0d_iso_held", idx), 32'(iso_low), 32'd0);
    check($sformatf("v%0d_rows_off", idx), 32'(SW_EN), 32'd0);
  endtask

  initial begin
    bit found;
    vecs[0] = '{8'd4, 4, -1, 0, -1, 34, 35};
    vecs[1] = '{8'd0, 1, -1, 0, -1, 10, 11};
    vecs[2] = '{8'd1, 1, -1, 0, -1, 10, 11};
    vecs[3] = '{8'd3, 3, -1, 0, -1, 26, 27};
    vecs[4] = '{8'd4, 4,  5, 3, -1, 34, 35};
    vecs[5] = '{8'd2, 2, -1, 0,  3, 18, 19};

    RST = 1'b1;
    PWR_REQ = 1'b0;
    DWELL = 8'd4;
    repeat (3) tick();
    check("rst_sw_en", 32'(SW_EN), 32'd0);
    check("rst_iso", 32'(ISO), 32'd1);
    check("rst_ack", 32'(PWR_ACK), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_save", 32'(SAVE), 32'd0);
    check("rst_restore", 32'(RESTORE), 32'd0);
    RST = 1'b0;
    repeat (2) tick();
    check("idle_busy", 32'(BUSY), 32'd0);

    for (int v = 0; v < 6; v++) begin
      power_up(vecs[v], v);
      power_down(vecs[v], v, (vecs[v].drop_at >= 0) ? 0 : 1);
      repeat (3) tick();
    end

    // Reset while half the rows are still powered during ramp-down.
    power_up(vecs[0], 6);
    PWR_REQ = 1'b0;
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      tick();
      if (SW_EN === 8'h0F) found = 1;
    end
    check("rst_mid_reach_0f", 32'(found), 32'd1);
    RST = 1'b1;
    tick();
    check("rst_mid_sw_en", 32'(SW_EN), 32'd0);
    check("rst_mid_iso", 32'(ISO), 32'd1);
    check("rst_mid_busy", 32'(BUSY), 32'd0);
    check("rst_mid_ack", 32'(PWR_ACK), 32'd0);
    RST = 1'b0;
    repeat (3) tick();
    check("post_rst_busy", 32'(BUSY), 32'd0);
    check("post_rst_sw_en", 32'(SW_EN), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__pwr_row_seq.md
# gf180mcu_fd_sc_mcu9t5v0__pwr_row_seq

Power-row sequencer for a power-gated region built from endcap-bounded standard-cell rows. It switches the header switch cells row by row with a programmable dwell between rows to limit rush current. It also orders isolation and retention save/restore around each transition. It sits between the always-on power controller (PWR_REQ/PWR_ACK) and the switch, isolation and retention control nets of the gated rows.

## Interface
- NROWS, 8: number of switchable rows (≥2); width of SW_EN.
- DWELL_W, 8: width of the DWELL input.
- CLK in 1: always-on clock; all state changes on the rising edge.
- RST in 1: synchronous, active-high reset.
- PWR_REQ in 1: level request; 1 = region on, 0 = region off.
- DWELL in DWELL_W: cycles between successive row switches; latched at sequence start; 0 is treated as 1 (D = max(DWELL,1)).
- PWR_ACK out 1: 1 only in ON (powered, de-isolated, restored).
- BUSY out 1: 1 in every state except OFF and ON.
- SW_EN out NROWS: per-row switch enable, thermometer-coded from bit 0.
- ISO out 1: isolation clamp, 1 = clamped.
- SAVE out 1: one-cycle retention save pulse.
- RESTORE out 1: one-cycle retention restore pulse.

## Operation
- States: OFF, RAMP_UP, RESTORE, ON, ISO, SAVE, RAMP_DN.
- OFF: SW_EN=0, ISO=1, ACK=0. PWR_REQ=1 → RAMP_UP; latch D; SW_EN=1 (row 0); row counter=0.
- RAMP_UP: every D cycles, shift one more 1 into SW_EN. After the last row is set, wait D more cycles, then go to RESTORE.
- RESTORE: RESTORE=1 for one cycle, ISO still 1 → ON.
- ON: ISO=0, ACK=1. PWR_REQ=0 → ISO.
- ISO: ISO=1, ACK=0, one cycle → SAVE.
- SAVE: SAVE=1 for one cycle → RAMP_DN; clear SW_EN[NROWS-1] on entry.
- RAMP_DN: every D cycles, clear the next-lower row. D cycles after SW_EN[0] clears → OFF.
- PWR_REQ is sampled only in OFF and ON. Toggles during BUSY are ignored; the sequence always completes, then the level is re-evaluated.
- ISO is never 0 unless SW_EN is all ones. SAVE and RESTORE are never asserted together.
- Dwell counter counts D-1 down to 0. A DWELL change mid-sequence has no effect.

## Timing
- Reset values: SW_EN=0, ISO=1, SAVE=0, RESTORE=0, PWR_ACK=0, BUSY=0, state OFF.
- Power-up, with PWR_REQ sampled high at edge k:
  - SW_EN[i] rises at edge k+1+i·D.
  - RESTORE is high for the cycle after edge k+1+NROWS·D.
  - ISO falls and ACK rises at edge k+2+NROWS·D.
- Power-down, with PWR_REQ sampled low at edge j:
  - ACK falls and state ISO at edge j+1.
  - SAVE is high after edge j+2.
  - SW_EN[NROWS-1-i] falls at edge j+3+i·D.
  - BUSY falls at edge j+3+NROWS·D.
- Minimum cycle: the power-down sequence starts at the first ON cycle where PWR_REQ=0. No bypass path exists.
- RST mid-sequence: reset values at the next edge, including all rows dropped at once. This is a power-on reset only; the controller never issues it during operation.

## Structure
- Shared package gf180mcu_fd_sc_mcu9t5v0__pwr_pkg holds:
  - the state enum (the seven states above);
  - the constant for the DWELL=0 substitution value (1).
- One sub-module, gf180mcu_fd_sc_mcu9t5v0__pwr_dwell_cnt:
  - loads D-1 on start;
  - counts down;
  - pulses TICK when it reaches 0, then reloads.
- Top level holds the FSM, the row counter (clog2(NROWS) bits) and the registered outputs. All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- NROWS=8, DWELL=4, PWR_REQ rises at edge 10 → SW_EN bits rise at edges 11,15,…,39; RESTORE pulse after edge 43; ISO=0 and ACK=1 at edge 44.
- From ON, PWR_REQ falls at edge 100 → ACK=0 at 101; SAVE pulse after 102; SW_EN[7..0] fall at 103,107,…,131; BUSY=0 at 135; ISO stays 1 throughout.
- DWELL=0 → identical to DWELL=1: rows at consecutive edges; ACK at k+10 for NROWS=8.
- PWR_REQ pulses low for 3 cycles mid-RAMP_UP and DWELL changes mid-ramp → ramp and timing unchanged, ends in ON.
- PWR_REQ=0 mid-RAMP_UP → reaches ON, then immediately sequences down.
- RST asserted during RAMP_DN with SW_EN=0x0F → next edge SW_EN=0, ISO=1, BUSY=0, ACK=0.
- Invariant check run across all tests: ISO==0 implies SW_EN all ones; SAVE and RESTORE never both high.
